// File: rtl/impulse_count_receiver_if.sv
// ---------------------------------------------------------------------------
// impulse_count_receiver_if
// Serial readout link between the multi-channel impulse counter and the host
// side receiver.
//   serial_in  : count data, MSB first
//   sl_in      : 0 = load/idle, 1 = shift one bit per clk
//   addr_in    : channel address of the word being shifted
//   ovf_in     : global overflow line, sampled with the last bit
//   ovf_rtc_in : RTC overflow line
// Modports: master = counter side (drives), slave = receiver (samples).
// ---------------------------------------------------------------------------
interface impulse_count_receiver_if #(
    parameter int ADDR_W = 4
);
    logic              serial_in;
    logic              sl_in;
    logic [ADDR_W-1:0] addr_in;
    logic              ovf_in;
    logic              ovf_rtc_in;

    modport master (output serial_in, sl_in, addr_in, ovf_in, ovf_rtc_in);
    modport slave  (input  serial_in, sl_in, addr_in, ovf_in, ovf_rtc_in);
endinterface

// File: rtl/impulse_count_receiver.sv
// ---------------------------------------------------------------------------
// impulse_count_receiver
// Deserializes the counter's MSB-first readout stream, checks frame
// integrity, stores count + overflow flag per channel in a register bank and
// keeps a sticky flag for the RTC overflow line.
//
// Ports
//   clk, rst_n       : clock (rising edge), async active-low reset
//   link (slave)     : serial readout link (see impulse_count_receiver_if)
//   i_clr_sticky     : synchronous clear of o_rtc_ovf_sticky (set wins)
//   i_rd_sel         : bank read address
//   o_rd_data/o_rd_ovf : stored count / ovf flag for i_rd_sel (combinational,
//                        0 when i_rd_sel >= NUM_CH)
//   o_word_valid     : one-cycle pulse per complete word
//   o_word_data/o_word_addr : last received word and its address (held)
//   o_frame_error    : one-cycle pulse on an aborted or corrupted frame
//   o_rtc_ovf_sticky : set on a rising edge of ovf_rtc_in
//
// Build option: define RX_INPUT_SYNC_EN to pass every link input through a
// 2-flop synchronizer (counter chip on its own clock); adds 2 cycles latency.
// ---------------------------------------------------------------------------
module impulse_count_receiver #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 8,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    impulse_count_receiver_if.slave link,
    input  logic                   i_clr_sticky,
    input  logic [ADDR_W-1:0]      i_rd_sel,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic                   o_rd_ovf,
    output logic                   o_word_valid,
    output logic [WIDTH-1:0]       o_word_data,
    output logic [ADDR_W-1:0]      o_word_addr,
    output logic                   o_frame_error,
    output logic                   o_rtc_ovf_sticky
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W:0] NUM_CH_L = (ADDR_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_LOAD} state_t;

    // ---------------- input stage ----------------
    logic              w_ser, w_sl, w_ovf, w_rtc;
    logic [ADDR_W-1:0] w_addr;

`ifdef RX_INPUT_SYNC_EN
    logic [1:0]             r_ser_s, r_sl_s, r_ovf_s, r_rtc_s;
    logic [1:0][ADDR_W-1:0] r_addr_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ser_s  <= '0;
            r_sl_s   <= '0;
            r_ovf_s  <= '0;
            r_rtc_s  <= '0;
            r_addr_s <= '0;
        end else begin
            r_ser_s  <= {r_ser_s[0], link.serial_in};
            r_sl_s   <= {r_sl_s[0],  link.sl_in};
            r_ovf_s  <= {r_ovf_s[0], link.ovf_in};
            r_rtc_s  <= {r_rtc_s[0], link.ovf_rtc_in};
            r_addr_s <= {r_addr_s[0], link.addr_in};
        end
    end

    assign w_ser  = r_ser_s[1];
    assign w_sl   = r_sl_s[1];
    assign w_ovf  = r_ovf_s[1];
    assign w_rtc  = r_rtc_s[1];
    assign w_addr = r_addr_s[1];
`else
    assign w_ser  = link.serial_in;
    assign w_sl   = link.sl_in;
    assign w_ovf  = link.ovf_in;
    assign w_rtc  = link.ovf_rtc_in;
    assign w_addr = link.addr_in;
`endif

    // ---------------- state ----------------
    state_t            r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WIDTH-1:0]  r_shift;
    logic [ADDR_W-1:0] r_addr_lat;

    logic [WIDTH-1:0]  r_bank_cnt [NUM_CH];
    logic [NUM_CH-1:0] r_bank_ovf;

    logic              r_word_valid;
    logic [WIDTH-1:0]  r_word_data;
    logic [ADDR_W-1:0] r_word_addr;
    logic              r_frame_error;
    logic              r_rtc_d;
    logic              r_rtc_sticky;

    // ---------------- datapath / decode ----------------
    logic [WIDTH-1:0]  w_word;      // shift register after taking this bit
    logic [ADDR_W-1:0] w_addr_src;  // address the completing word belongs to
    logic              w_last;      // this cycle samples the final bit
    logic              w_err;       // this cycle aborts the frame
    logic              w_wr_in;     // completing word maps onto the bank
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_rd_in;

    always_comb begin
        w_word     = '0;
        w_addr_src = r_addr_lat;
        w_last     = 1'b0;
        w_err      = 1'b0;
        if (r_state == IDLE) begin
            // First bit lands at the LSB; after WIDTH shifts it is the MSB.
            w_word     = WIDTH'(w_ser);
            w_addr_src = w_addr;
            w_last     = w_sl && (WIDTH == 1);
        end else if (r_state == SHIFT) begin
            w_word = (r_shift << 1) | WIDTH'(w_ser);
            w_err  = !w_sl || (w_addr != r_addr_lat);
            w_last = !w_err && (r_bit_cnt == CNT_W'(WIDTH - 1));
        end
    end

    assign w_wr_in  = ({1'b0, w_addr_src} < NUM_CH_L);
    assign w_wr_idx = w_addr_src[IDX_W-1:0];
    assign w_rd_in  = ({1'b0, i_rd_sel} < NUM_CH_L);
    assign w_rd_idx = i_rd_sel[IDX_W-1:0];

    // ---------------- FSM + registered outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_addr_lat    <= '0;
            r_bank_ovf    <= '0;
            r_word_valid  <= 1'b0;
            r_word_data   <= '0;
            r_word_addr   <= '0;
            r_frame_error <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_bank_cnt[i] <= '0;
        end else begin
            r_word_valid  <= w_last;
            r_frame_error <= w_err;

            // Word and bank update on the edge entering the valid cycle, so a
            // same-address read during word_valid already sees the new value.
            if (w_last) begin
                r_word_data <= w_word;
                r_word_addr <= w_addr_src;
                if (w_wr_in) begin
                    r_bank_cnt[w_wr_idx] <= w_word;
                    r_bank_ovf[w_wr_idx] <= w_ovf;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_sl) begin
                        r_shift    <= w_word;
                        r_addr_lat <= w_addr;
                        r_bit_cnt  <= CNT_W'(1);
                        r_state    <= (WIDTH == 1) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_err) begin
                        r_bit_cnt <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_shift   <= w_word;
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (w_last) r_state <= DONE;
                    end
                end
                DONE: begin
                    r_bit_cnt <= '0;
                    r_state   <= w_sl ? WAIT_LOAD : IDLE;
                end
                WAIT_LOAD: begin
                    // Surplus bits are dropped until the counter goes back to load.
                    if (!w_sl) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ---------------- RTC overflow sticky ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rtc_d      <= 1'b0;
            r_rtc_sticky <= 1'b0;
        end else begin
            r_rtc_d <= w_rtc;
            if (w_rtc && !r_rtc_d)  r_rtc_sticky <= 1'b1;   // set beats clear
            else if (i_clr_sticky)  r_rtc_sticky <= 1'b0;
        end
    end

    // ---------------- read port ----------------
    always_comb begin
        o_rd_data = '0;
        o_rd_ovf  = 1'b0;
        if (w_rd_in) begin
            o_rd_data = r_bank_cnt[w_rd_idx];
            o_rd_ovf  = r_bank_ovf[w_rd_idx];
        end
    end

    assign o_word_valid     = r_word_valid;
    assign o_word_data      = r_word_data;
    assign o_word_addr      = r_word_addr;
    assign o_frame_error    = r_frame_error;
    assign o_rtc_ovf_sticky = r_rtc_sticky;

endmodule

// File: tb/tb_impulse_count_receiver.sv
module tb_impulse_count_receiver;
    localparam int WIDTH  = 16;
    localparam int NUM_CH = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr_sticky;
    logic [ADDR_W-1:0] rd_sel;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_ovf;
    logic              word_valid;
    logic [WIDTH-1:0]  word_data;
    logic [ADDR_W-1:0] word_addr;
    logic              frame_error;
    logic              rtc_ovf_sticky;

    int total = 0;
    int bad   = 0;
    int nv    = 0;
    int ne    = 0;

    always #5 clk = ~clk;

    impulse_count_receiver_if #(.ADDR_W(ADDR_W)) lnk ();

    impulse_count_receiver #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .link             (lnk),
        .i_clr_sticky     (clr_sticky),
        .i_rd_sel         (rd_sel),
        .o_rd_data        (rd_data),
        .o_rd_ovf         (rd_ovf),
        .o_word_valid     (word_valid),
        .o_word_data      (word_data),
        .o_word_addr      (word_addr),
        .o_frame_error    (frame_error),
        .o_rtc_ovf_sticky (rtc_ovf_sticky)
    );

    // Pulse counters; also flags valid and error in the same cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (word_valid)  nv++;
            if (frame_error) ne++;
            if (word_valid && frame_error) begin
                bad++;
                $display("FAIL valid_and_error_same_cycle: got both high, need at most one");
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, need %0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [3:0] a, input logic [15:0] d, input int n,
                              input int chg_at, input logic [3:0] ca, input logic ov);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            lnk.sl_in     = 1'b1;
            lnk.serial_in = d[15-i];
            lnk.addr_in   = (chg_at >= 0 && i >= chg_at) ? ca : a;
            lnk.ovf_in    = ov && (i == 15);
        end
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        int          nbits;
        int          chg_at;
        logic [3:0]  chg_addr;
        logic        ovf;
        logic [3:0]  rd_a;
        logic [15:0] exp_rd_a;
        logic        exp_ovf_a;
        logic [3:0]  rd_b;
        logic [15:0] exp_rd_b;
        int          exp_nv;
        int          exp_ne;
        logic [15:0] exp_wdata;
        logic [3:0]  exp_waddr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int nv0, ne0;
        vecs[0] = '{4'd3, 16'hA5C3, 16, -1, 4'd0, 1'b0, 4'd3, 16'hA5C3, 1'b0, 4'd3, 16'hA5C3, 1, 0, 16'hA5C3, 4'd3};
        vecs[1] = '{4'd3, 16'h1111,  9, -1, 4'd0, 1'b0, 4'd3, 16'hA5C3, 1'b0, 4'd3, 16'hA5C3, 0, 1, 16'hA5C3, 4'd3};
        vecs[2] = '{4'd5, 16'h5555, 16,  7, 4'd6, 1'b0, 4'd5, 16'h0000, 1'b0, 4'd6, 16'h0000, 0, 2, 16'hA5C3, 4'd3};
        vecs[3] = '{4'd2, 16'hBEEF, 16, -1, 4'd0, 1'b1, 4'd2, 16'hBEEF, 1'b1, 4'd3, 16'hA5C3, 1, 0, 16'hBEEF, 4'd2};
        vecs[4] = '{4'd9, 16'h1234, 16, -1, 4'd0, 1'b0, 4'd9, 16'h0000, 1'b0, 4'd2, 16'hBEEF, 1, 0, 16'h1234, 4'd9};
        vecs[5] = '{4'd7, 16'h8001, 16, -1, 4'd0, 1'b0, 4'd7, 16'h8001, 1'b0, 4'd8, 16'h0000, 1, 0, 16'h8001, 4'd7};
        vecs[6] = '{4'd8, 16'h00FF, 16, -1, 4'd0, 1'b1, 4'd8, 16'h0000, 1'b0, 4'd7, 16'h8001, 1, 0, 16'h00FF, 4'd8};

        lnk.serial_in = 1'b0; lnk.sl_in = 1'b0; lnk.addr_in = '0;
        lnk.ovf_in = 1'b0; lnk.ovf_rtc_in = 1'b0;
        clr_sticky = 1'b0; rd_sel = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_word_valid", 32'(word_valid), 0);
        chk("rst_word_data", 32'(word_data), 0);
        chk("rst_word_addr", 32'(word_addr), 0);
        chk("rst_frame_error", 32'(frame_error), 0);
        chk("rst_sticky", 32'(rtc_ovf_sticky), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- table-driven frames ----------------
        for (int k = 0; k < 7; k++) begin
            nv0 = nv; ne0 = ne;
            rd_sel = vecs[k].addr;
            send_frame(vecs[k].addr, vecs[k].data, vecs[k].nbits,
                       vecs[k].chg_at, vecs[k].chg_addr, vecs[k].ovf);
            @(negedge clk);
            // cycle right after the last sampled bit
            chk($sformatf("v%0d_valid_latency", k), 32'(word_valid), (vecs[k].exp_nv == 1) ? 1 : 0);
            if (vecs[k].exp_nv == 1)
                chk($sformatf("v%0d_bypass_rd", k), 32'(rd_data),
                    (vecs[k].addr < NUM_CH) ? 32'(vecs[k].data) : 0);
            lnk.sl_in = 1'b0; lnk.ovf_in = 1'b0;
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_nvalid", k), 32'(nv - nv0), 32'(vecs[k].exp_nv));
            chk($sformatf("v%0d_nerr", k), 32'(ne - ne0), 32'(vecs[k].exp_ne));
            chk($sformatf("v%0d_word_data", k), 32'(word_data), 32'(vecs[k].exp_wdata));
            chk($sformatf("v%0d_word_addr", k), 32'(word_addr), 32'(vecs[k].exp_waddr));
            rd_sel = vecs[k].rd_a; #1;
            chk($sformatf("v%0d_rd_a", k), 32'(rd_data), 32'(vecs[k].exp_rd_a));
            chk($sformatf("v%0d_ovf_a", k), 32'(rd_ovf), 32'(vecs[k].exp_ovf_a));
            rd_sel = vecs[k].rd_b; #1;
            chk($sformatf("v%0d_rd_b", k), 32'(rd_data), 32'(vecs[k].exp_rd_b));
        end

        // ---------------- RTC sticky ----------------
        @(negedge clk); lnk.ovf_rtc_in = 1'b1;
        @(negedge clk); chk("rtc_set", 32'(rtc_ovf_sticky), 1);
        lnk.ovf_rtc_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rtc_hold", 32'(rtc_ovf_sticky), 1);
        lnk.ovf_rtc_in = 1'b1; clr_sticky = 1'b1;
        @(negedge clk); chk("rtc_set_beats_clr", 32'(rtc_ovf_sticky), 1);
        clr_sticky = 1'b0;
        @(negedge clk); clr_sticky = 1'b1;
        @(negedge clk); chk("rtc_clear", 32'(rtc_ovf_sticky), 0);
        clr_sticky = 1'b0;
        @(negedge clk); chk("rtc_level_no_reset", 32'(rtc_ovf_sticky), 0);
        lnk.ovf_rtc_in = 1'b0;
        @(negedge clk);

        // ---------------- back-to-back frames ----------------
        send_frame(4'd0, 16'hFFFF, 16, -1, 4'd0, 1'b0);
        @(negedge clk);
        chk("b2b0_valid", 32'(word_valid), 1);
        chk("b2b0_data", 32'(word_data), 32'hFFFF);
        lnk.sl_in = 1'b0;   // single load cycle between frames
        send_frame(4'd1, 16'h0001, 16, -1, 4'd0, 1'b0);
        @(negedge clk);
        chk("b2b1_valid", 32'(word_valid), 1);
        chk("b2b1_data", 32'(word_data), 32'h0001);
        chk("b2b1_addr", 32'(word_addr), 1);
        lnk.sl_in = 1'b0;
        repeat (2) @(negedge clk);
        rd_sel = 4'd0; #1; chk("b2b_rd0", 32'(rd_data), 32'hFFFF);
        rd_sel = 4'd1; #1; chk("b2b_rd1", 32'(rd_data), 32'h0001);

        // ---------------- reset mid-frame ----------------
        nv0 = nv; ne0 = ne;
        send_frame(4'd4, 16'hABCD, 8, -1, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; lnk.sl_in = 1'b0;
        #1;
        chk("mrst_word_valid", 32'(word_valid), 0);
        chk("mrst_word_data", 32'(word_data), 0);
        chk("mrst_word_addr", 32'(word_addr), 0);
        chk("mrst_frame_error", 32'(frame_error), 0);
        chk("mrst_sticky", 32'(rtc_ovf_sticky), 0);
        for (int c = 0; c < NUM_CH; c++) begin
            rd_sel = 4'(c); #1;
            chk($sformatf("mrst_bank%0d", c), 32'(rd_data), 0);
            chk($sformatf("mrst_ovf%0d", c), 32'(rd_ovf), 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mrst_no_pulse_valid", 32'(nv - nv0), 0);
        chk("mrst_no_pulse_err", 32'(ne - ne0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/impulse_count_receiver.md
Name: impulse_count_receiver

Overview:
- Host-side receiving end of the multi-channel impulse counter's serial readout interface.
- Deserializes the MSB-first count stream qualified by SL (shift/load) and the 4-bit channel address, and checks frame integrity.
- Stores the latest count and overflow flag per channel in a register bank with a random-access read port.
- Tracks the RTC overflow line as a sticky flag.
- Same clock domain as the counter core; sits between the counter pins and the host/test logic.

Parameters:
- WIDTH, 16, bits per channel count word.
- NUM_CH, 8, number of channels stored in the bank.
- ADDR_W, 4, channel address width (a0..a3).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- serial_in  in  1  serial count data, MSB first.
- sl_in  in  1  0 = load/idle, 1 = shift one bit per clk.
- addr_in  in  ADDR_W  channel address of the word being shifted.
- ovf_in  in  1  global overflow line from the counter.
- ovf_rtc_in  in  1  RTC overflow line.
- clr_sticky  in  1  synchronous clear of rtc_ovf_sticky.
- rd_sel  in  ADDR_W  bank read address.
- rd_data  out  WIDTH  stored count for rd_sel, combinational from the bank.
- rd_ovf  out  1  stored overflow flag for rd_sel.
- word_valid  out  1  one-cycle pulse when a complete word is received.
- word_data  out  WIDTH  last received word; held until the next valid word.
- word_addr  out  ADDR_W  address of the last received word.
- frame_error  out  1  one-cycle pulse on an aborted or corrupted frame.
- rtc_ovf_sticky  out  1  set on an ovf_rtc_in rising edge.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, bit counter 0, shift reg 0, bank counts 0, bank ovf flags 0, word_valid=0, word_data=0, word_addr=0, frame_error=0, rtc_ovf_sticky=0, ovf_rtc_in edge-detect register=0.
- Reset mid-frame discards the partial word; no pulse is emitted.
- IDLE:
  - sl_in=0: remain in IDLE.
  - sl_in=1: capture serial_in as the MSB and latch addr_in into addr_lat. Set bit count to 1. Go to SHIFT.
  - If WIDTH=1, go directly to DONE.
- SHIFT:
  - Each cycle with sl_in=1: shift serial_in in at the LSB end and increment the count.
  - On the cycle the WIDTH-th bit is sampled, also sample ovf_in. Go to DONE.
- DONE (one cycle):
  - word_valid=1. word_data and word_addr update on this same edge.
  - If addr_lat < NUM_CH, write the bank entry (count plus ovf flag); if addr_lat >= NUM_CH, pulse word_valid but do not write the bank.
  - Next state: IDLE if sl_in=0, else WAIT_LOAD.
- WAIT_LOAD:
  - Any extra bits while sl_in=1 are ignored (no error).
  - Return to IDLE when sl_in=0.
- Latency: word_valid is high in the clock cycle immediately after the cycle in which the last bit is sampled.
- Frame errors, both causing a one-cycle frame_error pulse, a return to IDLE, and no bank write:
  - sl_in=0 in SHIFT before WIDTH bits have been received.
  - addr_in != addr_lat on any SHIFT cycle.
- word_valid and frame_error are never high in the same cycle.
- Bank bypass: the bank write occurs on the edge entering the word_valid cycle. A read of the same address during the word_valid cycle returns the new value.
- rd_sel >= NUM_CH: rd_data=0, rd_ovf=0.
- RTC sticky:
  - rtc_ovf_sticky sets on a 0->1 transition of ovf_rtc_in (one edge-detect register).
  - clr_sticky clears it. If a set and clr_sticky occur in the same cycle, set wins.
- Back-to-back frames: a word whose first bit is sampled in the cycle after the DONE cycle is received correctly, provided sl_in dropped to 0 in the DONE cycle.

Optional Feature:
- RX_INPUT_SYNC_EN.
- Defined:
  - serial_in, sl_in, addr_in, ovf_in and ovf_rtc_in each pass through a 2-flop synchronizer, reset to 0.
  - All latencies increase by 2 cycles.
  - Supports an asynchronous counter-chip clock.
- Undefined: inputs are used directly; all inputs must be synchronous to clk.

Test Plan:
- Reset, then sl_in=1 for 16 cycles with addr_in=3 and serial bits 0xA5C3 MSB first, ovf_in=0 -> word_valid pulses in the next cycle with word_data=0xA5C3 and word_addr=3; rd_sel=3 gives rd_data=0xA5C3, rd_ovf=0.
- Same frame but with sl_in dropped to 0 after 9 bits -> frame_error pulses once, no word_valid, rd_data at address 3 unchanged.
- Frame with addr_in changing from 5 to 6 at bit 7 -> frame_error pulses; address 5 and address 6 are not written.
- Frame to address 2 with ovf_in=1 on the last bit -> rd_ovf=1 at rd_sel=2. A frame to address 9 with data 0x1234 -> word_valid pulses with word_addr=9, and rd_sel=9 gives 0.
- ovf_rtc_in pulses 0->1->0 -> rtc_ovf_sticky=1 and holds. clr_sticky coinciding with a new rising edge -> remains 1. clr_sticky alone -> 0.
- Two back-to-back frames (addr 0 = 0xFFFF, addr 1 = 0x0001) separated by a single sl_in=0 cycle, then rst_n asserted in the middle of a third frame -> both words are stored; after reset all outputs are 0 and the bank reads 0.
